// File: rtl/nn_pkg.sv
// Shared numeric types for the ReLU forward/backward datapath.
// The activation word width and its signed word type live here so both directions agree.
package nn_pkg;

  localparam int W      = 17;
  localparam int ZCNT_W = 8;

  typedef logic signed [W-1:0] data_t;

endpackage

// File: rtl/relu_mask_fifo.sv
// One-bit-wide FIFO that stores forward ReLU masks until the matching gradient arrives.
// The caller gates push/pop with its own ready terms; this block only stores and counts.
module relu_mask_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: the storage array is not reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: records the forward sign mask, then gates incoming gradients by it.
// Zero pre-activations pass the gradient, matching the forward ReLU that passes zero.
module relu_backward
  import nn_pkg::ZCNT_W;
#(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fwd_valid,
  output logic                       fwd_ready,
  input  logic signed [W-1:0]        fwd_in,
  input  logic                       bwd_valid,
  output logic                       bwd_ready,
  input  logic signed [W-1:0]        bwd_grad,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [W-1:0]        out_grad,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [ZCNT_W-1:0]          zeroed_cnt,
  input  logic                       flush
);

  localparam int CW = $clog2(DEPTH+1);

  logic push;
  logic pop;
  logic mask;

  // fwd_ready looks only at registered count, so a same-cycle pop never frees a slot early.
  assign fwd_ready = (count < CW'(DEPTH));
  assign bwd_ready = (count != '0) && (!out_valid || out_ready);
  assign push      = fwd_valid && fwd_ready && !flush;
  assign pop       = bwd_valid && bwd_ready && !flush;

  relu_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_mask_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (~fwd_in[W-1]),
    .pop   (pop),
    .dout  (mask),
    .count (count)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_grad   <= '0;
      zeroed_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_grad  <= mask ? bwd_grad : '0;
      if (!mask && zeroed_cnt != '1) zeroed_cnt <= zeroed_cnt + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward with hand-computed expected gradients and counters.
module tb_relu_backward;
  import nn_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fwd_valid, fwd_ready;
  data_t       fwd_in;
  logic        bwd_valid, bwd_ready;
  data_t       bwd_grad;
  logic        out_valid, out_ready;
  data_t       out_grad;
  logic [4:0]  count;
  logic [7:0]  zeroed_cnt;
  logic        flush;

  int checks   = 0;
  int failures = 0;
  int exp_z    = 0;
  bit mask_q[$];

  relu_backward #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_in     (fwd_in),
    .bwd_valid  (bwd_valid),
    .bwd_ready  (bwd_ready),
    .bwd_grad   (bwd_grad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .count      (count),
    .zeroed_cnt (zeroed_cnt),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fwd_valid = 1'b0; fwd_in = '0;
    bwd_valid = 1'b0; bwd_grad = '0; out_ready = 1'b1;

    // Reset values are visible from the first edge with rst_n low.
    tick;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_grad", int'(out_grad), 0);
    check("rst_zeroed", int'(zeroed_cnt), 0);
    check("rst_fwd_ready", int'(fwd_ready), 1);
    check("rst_bwd_ready", int'(bwd_ready), 0);
    tick;
    rst_n = 1'b1;

    // Basic gating: 100, -5, 0 gate gradient 7 to 7, 0, 7.
    fwd_valid = 1'b1;
    fwd_in = 100; tick;
    fwd_in = -5;  tick;
    fwd_in = 0;   tick;
    fwd_valid = 1'b0;
    check("basic_count3", int'(count), 3);
    bwd_valid = 1'b1; bwd_grad = 7;
    tick;
    check("basic_v0", int'(out_valid), 1);
    check("basic_g0", int'(out_grad), 7);
    tick;
    check("basic_g1", int'(out_grad), 0);
    tick;
    check("basic_g2", int'(out_grad), 7);
    bwd_valid = 1'b0;
    exp_z = 1;
    check("basic_zeroed", int'(zeroed_cnt), exp_z);
    check("basic_count0", int'(count), 0);
    tick;
    check("basic_drained", int'(out_valid), 0);

    // Empty: pop request is refused until a word has been pushed.
    bwd_valid = 1'b1; #1;
    check("empty_bwd_ready", int'(bwd_ready), 0);
    tick;
    check("empty_out_valid", int'(out_valid), 0);
    fwd_valid = 1'b1; fwd_in = 1;
    tick;
    fwd_valid = 1'b0; #1;
    check("one_bwd_ready", int'(bwd_ready), 1);
    tick;
    check("one_out_valid", int'(out_valid), 1);
    check("one_out_grad", int'(out_grad), 7);
    bwd_valid = 1'b0;
    tick;
    check("one_drained", int'(out_valid), 0);

    // Full: 16 alternating-sign words, a 17th is refused, one pop reopens.
    fwd_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_in = (i % 2 == 0) ? (i + 1) : -(i + 1);
      tick;
    end
    check("full_count", int'(count), 16);
    check("full_fwd_ready", int'(fwd_ready), 0);
    fwd_in = 5;
    tick;
    check("full_17th_refused", int'(count), 16);
    bwd_valid = 1'b1; bwd_grad = 11;
    tick;
    check("full_pop_count", int'(count), 15);
    check("full_pop_grad", int'(out_grad), 11);
    fwd_valid = 1'b0; #1;
    check("full_reopen", int'(fwd_ready), 1);
    for (int i = 1; i < DEPTH; i++) begin
      tick;
      if (i % 2 == 1) exp_z++;
      check($sformatf("full_drain%0d", i), int'(out_grad), (i % 2 == 0) ? 11 : 0);
    end
    bwd_valid = 1'b0;
    tick;
    check("full_empty", int'(count), 0);
    check("full_zeroed", int'(zeroed_cnt), exp_z);

    // Backpressure: -3 holds while out_ready is low and bwd_ready stays low.
    fwd_valid = 1'b1; fwd_in = 50;
    tick; tick;
    fwd_valid = 1'b0; out_ready = 1'b0;
    bwd_valid = 1'b1; bwd_grad = -3;
    tick;
    check("bp_valid", int'(out_valid), 1);
    check("bp_grad", int'(out_grad), -3);
    bwd_grad = 9; #1;
    check("bp_bwd_ready_low", int'(bwd_ready), 0);
    tick; tick;
    check("bp_hold_grad", int'(out_grad), -3);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_count", int'(count), 1);
    out_ready = 1'b1; #1;
    check("bp_bwd_ready_high", int'(bwd_ready), 1);
    tick;
    check("bp_next_grad", int'(out_grad), 9);
    bwd_valid = 1'b0;
    tick;
    check("bp_drained", int'(out_valid), 0);
    check("bp_count", int'(count), 0);

    // Wrap: 3 entries in flight, then 40 simultaneous push/pop pairs.
    fwd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fwd_in = (i == 1) ? -3 : 3;
      mask_q.push_back(i != 1);
      tick;
    end
    bwd_valid = 1'b1; bwd_grad = 13;
    for (int i = 0; i < 40; i++) begin
      bit m;
      fwd_in = (i % 2 == 1) ? -(i + 1) : (i + 1);
      mask_q.push_back(i % 2 == 0);
      tick;
      m = mask_q.pop_front();
      if (!m) exp_z++;
      check($sformatf("wrap_grad%0d", i), int'(out_grad), m ? 13 : 0);
      check($sformatf("wrap_count%0d", i), int'(count), 3);
    end
    fwd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit m;
      tick;
      m = mask_q.pop_front();
      if (!m) exp_z++;
      check($sformatf("wrap_drain%0d", i), int'(out_grad), m ? 13 : 0);
    end
    bwd_valid = 1'b0;
    tick;
    check("wrap_zeroed", int'(zeroed_cnt), exp_z);

    // Flush with 5 entries and a held output; zeroed_cnt survives.
    out_ready = 1'b0; fwd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fwd_in = (i == 0) ? -1 : 4;
      tick;
    end
    fwd_valid = 1'b0; bwd_valid = 1'b1; bwd_grad = 21;
    tick;
    exp_z++;
    check("pre_flush_count", int'(count), 5);
    check("pre_flush_valid", int'(out_valid), 1);
    flush = 1'b1; fwd_valid = 1'b1; out_ready = 1'b1;
    tick;
    check("flush_count", int'(count), 0);
    check("flush_valid", int'(out_valid), 0);
    check("flush_zeroed", int'(zeroed_cnt), exp_z);
    flush = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0;

    // Reset mid-stream with 5 entries and a held output; everything clears.
    out_ready = 1'b0; fwd_valid = 1'b1; fwd_in = 4;
    for (int i = 0; i < 6; i++) tick;
    fwd_valid = 1'b0; bwd_valid = 1'b1;
    tick;
    check("pre_rst_count", int'(count), 5);
    check("pre_rst_grad", int'(out_grad), 21);
    rst_n = 1'b0; fwd_valid = 1'b1; out_ready = 1'b1;
    tick;
    check("midrst_count", int'(count), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_grad", int'(out_grad), 0);
    check("midrst_zeroed", int'(zeroed_cnt), 0);
    rst_n = 1'b1; fwd_valid = 1'b0; bwd_valid = 1'b0;
    tick;

    // Saturation: 260 masked gradients leave zeroed_cnt at 255.
    fwd_valid = 1'b1; fwd_in = -1;
    tick;
    bwd_valid = 1'b1; bwd_grad = 2;
    for (int i = 0; i < 260; i++) tick;
    check("sat_zeroed", int'(zeroed_cnt), 255);
    check("sat_grad", int'(out_grad), 0);
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
